// File: rtl/textlcd_pkg.sv
// Shared constants, instruction classes and address-counter helpers for the
// HD44780-style text LCD responder.
package textlcd_pkg;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_BASE   = 7'h00;
  localparam logic [6:0] LINE2_BASE   = 7'h40;
  localparam logic [6:0] AC_LINE1_END = 7'h27;
  localparam logic [6:0] AC_LINE2_END = 7'h67;

  localparam int unsigned LINE_LEN  = 16;
  localparam int unsigned NUM_CHARS = 2 * LINE_LEN;
  localparam int unsigned IDX_W     = $clog2(NUM_CHARS);

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISPLAY,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } ins_e;

  // Instruction class is chosen by the highest set bit of the byte.
  function automatic ins_e decode_ins(input logic [7:0] d);
    if ((d & OP_DDRAM) != 8'h00)        return INS_DDRAM;
    else if ((d & OP_CGRAM) != 8'h00)   return INS_CGRAM;
    else if ((d & OP_FUNC) != 8'h00)    return INS_FUNC;
    else if ((d & OP_SHIFT) != 8'h00)   return INS_SHIFT;
    else if ((d & OP_DISPLAY) != 8'h00) return INS_DISPLAY;
    else if ((d & OP_ENTRY) != 8'h00)   return INS_ENTRY;
    else if ((d & OP_HOME) != 8'h00)    return INS_HOME;
    else if ((d & OP_CLEAR) != 8'h00)   return INS_CLEAR;
    else                                return INS_NOP;
  endfunction

  // Step the DDRAM address counter, jumping between the two line windows.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == AC_LINE1_END)      return LINE2_BASE;
      else if (ac == AC_LINE2_END) return LINE1_BASE;
      else                         return ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)        return AC_LINE2_END;
      else if (ac == LINE2_BASE)   return AC_LINE1_END;
      else                         return ac - 7'd1;
    end
  endfunction

  function automatic logic ac_visible(input logic [6:0] ac);
    return ac[5:4] == 2'b00;
  endfunction

  function automatic logic [IDX_W-1:0] ac_index(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/textlcd_bus_sync.sv
// Synchronizes the LCD bus, detects falling edges of en and presents the
// last captured rs/rw/data as a one-cycle transfer.
module textlcd_bus_sync
  import textlcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  output logic       xfer_valid,
  output logic       xfer_rs,
  output logic       xfer_rw,
  output logic [7:0] xfer_data
);

  localparam int unsigned BUS_W = 10;

  logic             r_en_s1, r_en_s2, r_en_s3;
  logic [BUS_W-1:0] r_bus_s1, r_bus_s2, r_cap;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_s1  <= 1'b0;
      r_en_s2  <= 1'b0;
      r_en_s3  <= 1'b0;
      r_bus_s1 <= '0;
      r_bus_s2 <= '0;
      r_cap    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_en_s1  <= lcd_en;
      r_en_s2  <= r_en_s1;
      r_en_s3  <= r_en_s2;
      r_bus_s1 <= {lcd_rs, lcd_rw, lcd_data};
      r_bus_s2 <= r_bus_s1;
      // Bus is tracked while en is high; the value from its last high cycle wins.
      if (r_en_s2) r_cap <= r_bus_s2;
      r_valid  <= r_en_s3 & ~r_en_s2;
    end
  end

  assign xfer_valid = r_valid;
  assign xfer_rs    = r_cap[9];
  assign xfer_rw    = r_cap[8];
  assign xfer_data  = r_cap[7:0];

endmodule

// File: rtl/textlcd_responder.sv
// HD44780-compatible bus responder: decodes transfers into a 2x16 character
// image, address counter, display flags and busy timing.
module textlcd_responder
  import textlcd_pkg::*;
#(
  parameter int unsigned BUSY_SHORT = 1000,
  parameter int unsigned BUSY_LONG  = 41000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       busy,
  output logic       wr_strobe,
  output logic       overrun,
  output logic       rd_ignored
);

  localparam int unsigned CNT_W = $clog2(BUSY_LONG + 1);

  logic       w_xfer_valid, w_xfer_rs, w_xfer_rw;
  logic [7:0] w_xfer_data;
  ins_e       w_ins;
  logic       w_long;

  logic [7:0]       r_chars [NUM_CHARS];
  logic [7:0]       r_rd_data;
  logic [6:0]       r_ac;
  logic             r_disp, r_cur, r_blink, r_inc, r_dl, r_n, r_cgram;
  logic             r_busy, r_strobe, r_overrun, r_rd_ignored;
  logic [CNT_W-1:0] r_busy_cnt;

  textlcd_bus_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .xfer_valid (w_xfer_valid),
    .xfer_rs    (w_xfer_rs),
    .xfer_rw    (w_xfer_rw),
    .xfer_data  (w_xfer_data)
  );

  assign w_ins  = decode_ins(w_xfer_data);
  assign w_long = ~w_xfer_rs & ((w_ins == INS_CLEAR) | (w_ins == INS_HOME));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) r_chars[i] <= CHAR_SPACE;
      r_rd_data    <= CHAR_SPACE;
      r_ac         <= LINE1_BASE;
      r_disp       <= 1'b0;
      r_cur        <= 1'b0;
      r_blink      <= 1'b0;
      r_inc        <= 1'b1;
      r_dl         <= 1'b1;
      r_n          <= 1'b0;
      r_cgram      <= 1'b0;
      r_busy       <= 1'b0;
      r_busy_cnt   <= '0;
      r_strobe     <= 1'b0;
      r_overrun    <= 1'b0;
      r_rd_ignored <= 1'b0;
    end else begin
      r_strobe  <= 1'b0;
      r_rd_data <= r_chars[rd_addr];
      if (r_busy) begin
        if (r_busy_cnt == '0) r_busy <= 1'b0;
        else                  r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      end
      if (w_xfer_valid) begin
        if (r_busy) begin
          r_overrun <= 1'b1;
        end else if (w_xfer_rw) begin
          r_rd_ignored <= 1'b1;
        end else begin
          r_strobe   <= 1'b1;
          r_busy     <= 1'b1;
          r_busy_cnt <= w_long ? CNT_W'(BUSY_LONG - 1) : CNT_W'(BUSY_SHORT - 1);
          if (w_xfer_rs) begin
            // CGRAM writes are swallowed without touching the counter.
            if (!r_cgram) begin
              if (ac_visible(r_ac)) r_chars[ac_index(r_ac)] <= w_xfer_data;
              r_ac <= ac_step(r_ac, r_inc);
            end
          end else begin
            case (w_ins)
              INS_CLEAR: begin
                for (int i = 0; i < NUM_CHARS; i++) r_chars[i] <= CHAR_SPACE;
                r_ac  <= LINE1_BASE;
                r_inc <= 1'b1;
              end
              INS_HOME:    r_ac <= LINE1_BASE;
              INS_ENTRY:   r_inc <= w_xfer_data[1];
              INS_DISPLAY: begin
                r_disp  <= w_xfer_data[2];
                r_cur   <= w_xfer_data[1];
                r_blink <= w_xfer_data[0];
              end
              INS_SHIFT: if (!w_xfer_data[3]) r_ac <= ac_step(r_ac, w_xfer_data[2]);
              INS_FUNC: begin
                r_dl <= w_xfer_data[4];
                r_n  <= w_xfer_data[3];
              end
              INS_CGRAM: r_cgram <= 1'b1;
              INS_DDRAM: begin
                r_ac    <= w_xfer_data[6:0];
                r_cgram <= 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign ac          = r_ac;
  assign display_on  = r_disp;
  assign cursor_on   = r_cur;
  assign blink_on    = r_blink;
  assign entry_inc   = r_inc;
  assign func_8bit   = r_dl;
  assign func_2line  = r_n;
  assign busy        = r_busy;
  assign wr_strobe   = r_strobe;
  assign overrun     = r_overrun;
  assign rd_ignored  = r_rd_ignored;

endmodule

// File: tb/tb_textlcd_responder.sv
// Scoreboard bench for textlcd_responder: a behavioural display model predicts
// state after each executed transfer; a monitor checks it on every wr_strobe.
module tb_textlcd_responder;

  localparam int unsigned BUSY_SHORT = 1000;
  localparam int unsigned BUSY_LONG  = 41000;

  logic       clk = 1'b0;
  logic       reset, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic       display_on, cursor_on, blink_on, entry_inc, func_8bit, func_2line;
  logic       busy, wr_strobe, overrun, rd_ignored;

  always #5 clk = ~clk;

  textlcd_responder #(.BUSY_SHORT(BUSY_SHORT), .BUSY_LONG(BUSY_LONG)) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .func_8bit(func_8bit), .func_2line(func_2line),
    .busy(busy), .wr_strobe(wr_strobe), .overrun(overrun), .rd_ignored(rd_ignored)
  );

  typedef struct packed {
    logic [6:0] ac;
    logic disp, cur, blink, inc, dl, n;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_strobes = 0;

  // Behavioural display model
  logic [7:0] m_chars [32];
  int m_ac;
  bit m_disp, m_cur, m_blink, m_inc, m_dl, m_n, m_cg, m_long;

  function automatic int step_ac(input int a, input bit up);
    if (up) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : (a + 1) % 128;
    else    return (a == 0) ? 'h67 : (a == 'h40) ? 'h27 : (a + 127) % 128;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
    m_ac = 0; m_disp = 0; m_cur = 0; m_blink = 0;
    m_inc = 1; m_dl = 1; m_n = 0; m_cg = 0; m_long = 0;
  endtask

  task automatic model_exec(input bit rs, input int d);
    m_long = 0;
    if (rs) begin
      if (!m_cg) begin
        if ((m_ac % 64) < 16) m_chars[(m_ac / 64) * 16 + (m_ac % 16)] = 8'(d);
        m_ac = step_ac(m_ac, m_inc);
      end
    end else if (d >= 128) begin
      m_ac = d - 128; m_cg = 0;
    end else if (d >= 64) begin
      m_cg = 1;
    end else if (d >= 32) begin
      m_dl = 1'(d >> 4); m_n = 1'(d >> 3);
    end else if (d >= 16) begin
      if (((d >> 3) & 1) == 0) m_ac = step_ac(m_ac, 1'(d >> 2));
    end else if (d >= 8) begin
      m_disp = 1'(d >> 2); m_cur = 1'(d >> 1); m_blink = 1'(d);
    end else if (d >= 4) begin
      m_inc = 1'(d >> 1);
    end else if (d >= 2) begin
      m_ac = 0; m_long = 1;
    end else if (d == 1) begin
      for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
      m_ac = 0; m_inc = 1; m_long = 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every executed transfer must match the next predicted state.
  always @(negedge clk) begin
    exp_t e, got;
    if (!reset && wr_strobe === 1'b1) begin
      n_strobes++;
      n_tests++;
      got = {ac, display_on, cursor_on, blink_on, entry_inc, func_8bit, func_2line};
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got state 0x%0h, expected no transfer", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL strobe_state: got 0x%0h, expected 0x%0h", got, e);
        end
      end
    end
  end

  task automatic send(input bit rs, input bit rw, input int d, input int hi, input bit exec);
    exp_t e;
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = 8'(d); lcd_en = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_en = 1'b0;
    if (exec && !rw) begin
      model_exec(rs, d);
      e.ac = 7'(m_ac); e.disp = m_disp; e.cur = m_cur; e.blink = m_blink;
      e.inc = m_inc; e.dl = m_dl; e.n = m_n;
      q.push_back(e);
    end
  endtask

  task automatic wait_rise(output int lat);
    lat = 0;
    while (busy !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("busy_rise", int'(busy === 1'b1), 1);
  endtask

  task automatic wait_fall();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50000) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall", int'(busy === 1'b0), 1);
  endtask

  task automatic wait_idle(input bit long_win, input string name);
    int lat, cnt;
    wait_rise(lat);
    check("xfer_latency", lat, 4);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50000) begin
      cnt++;
      @(negedge clk);
    end
    check(name, cnt, long_win ? BUSY_LONG : BUSY_SHORT);
  endtask

  task automatic read_char(input int i, output logic [7:0] v);
    @(negedge clk) rd_addr = 5'(i);
    @(negedge clk) v = rd_data;
  endtask

  task automatic check_chars(input string name);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_char(i, v);
      check(name, int'(v), int'(m_chars[i]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int s0, lat, d;
    bit rs, rw;
    logic [7:0] v;
    reset = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0;
    lcd_data = 8'h00; rd_addr = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_busy", int'(busy), 0);
    check("reset_ac", int'(ac), 0);
    check("reset_func_8bit", int'(func_8bit), 1);
    check("reset_entry_inc", int'(entry_inc), 1);
    check("reset_overrun", int'(overrun), 0);
    check("reset_rd_data", int'(rd_data), 'h20);
    check_chars("reset_chars");

    send(0, 0, 'h38, 2, 1); wait_idle(m_long, "busy_len_38");
    check("func_2line", int'(func_2line), 1);
    send(0, 0, 'h0C, 1, 1); wait_idle(m_long, "busy_len_0C");
    check("display_on", int'(display_on), 1);
    check("cursor_on", int'(cursor_on), 0);
    send(0, 0, 'h06, 3, 1); wait_idle(m_long, "busy_len_06");
    send(0, 0, 'h01, 2, 1); wait_idle(m_long, "busy_len_clear");

    s0 = n_strobes;
    send(0, 0, 'h80, 2, 1); wait_idle(m_long, "busy_len_80");
    send(1, 0, 'h41, 2, 1); wait_idle(m_long, "busy_len_d41");
    send(1, 0, 'h42, 1, 1); wait_idle(m_long, "busy_len_d42");
    read_char(0, v); check("char0", int'(v), 'h41);
    read_char(1, v); check("char1", int'(v), 'h42);
    check("ac_after_writes", int'(ac), 2);
    check("strobe_count", n_strobes - s0, 3);

    send(0, 0, 'hA7, 2, 1); wait_idle(m_long, "busy_len_A7");
    send(1, 0, 'h58, 2, 1); wait_idle(m_long, "busy_len_d58");
    check("ac_wrap_27", int'(ac), 'h40);
    check_chars("hidden_write_chars");
    send(0, 0, 'hC0, 2, 1); wait_idle(m_long, "busy_len_C0");
    send(1, 0, 'h5A, 2, 1); wait_idle(m_long, "busy_len_d5A");
    read_char(16, v); check("char16", int'(v), 'h5A);

    // Second write lands while the first one's busy window is open.
    send(1, 0, 'h33, 2, 1); wait_rise(lat);
    send(1, 0, 'h77, 2, 0);
    wait_fall();
    check("overrun", int'(overrun), 1);
    check_chars("overrun_chars");

    send(1, 1, 'h66, 1, 0);
    repeat (8) @(negedge clk);
    check("rd_ignored", int'(rd_ignored), 1);
    check("rd_busy", int'(busy), 0);

    for (int it = 0; it < 20; it++) begin
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 7) == 0);
      d  = rs ? int'($urandom_range(0, 255)) : int'($urandom_range(4, 255));
      send(rs, rw, d, int'($urandom_range(1, 3)), !rw);
      if (!rw) wait_idle(m_long, "rand_busy_len");
      else repeat (8) @(negedge clk);
    end
    check("rand_ac", int'(ac), m_ac);
    check_chars("rand_chars");

    send(0, 0, 'h01, 2, 1); wait_rise(lat);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("abort_busy", int'(busy), 0);
    check("abort_overrun", int'(overrun), 0);
    check("abort_rd_ignored", int'(rd_ignored), 0);
    check("abort_ac", int'(ac), 0);
    check_chars("abort_chars");
    repeat (8) @(negedge clk);
    check("pending_expect", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
